// File: rtl/vsync.sv
// Vertical timing stage: counts scanlines from the hsync line tick, drives active-low
// VGA_VSYNC, VDISPLAY and the coarse row index VPIXEL. Optional FRAME_TICK via VSYNC_FRAME_TICK_EN.
module vsync #(
    parameter int V_PULSE       = 2,
    parameter int V_BP          = 29,
    parameter int V_DISP        = 480,
    parameter int V_FP          = 10,
    parameter int LINES_PER_ROW = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LINE_TICK,
    output logic [6:0] VPIXEL,
    output logic       VGA_VSYNC,
    output logic       VDISPLAY
`ifdef VSYNC_FRAME_TICK_EN
    ,
    output logic       FRAME_TICK
`endif
);

    localparam int V_TOTAL = V_PULSE + V_BP + V_DISP + V_FP;
    localparam int ROWS    = V_DISP / LINES_PER_ROW;

    localparam logic [9:0] LAST_LINE = 10'(V_TOTAL - 1);
    localparam logic [6:0] LAST_ROW  = 7'(ROWS - 1);
    localparam logic [2:0] LAST_SUB  = 3'(LINES_PER_ROW - 1);

    typedef enum logic [1:0] {
        PULSE       = 2'd0,
        BACK_PORCH  = 2'd1,
        DISPLAY     = 2'd2,
        FRONT_PORCH = 2'd3
    } state_t;

    // Last line of each phase, indexed by the state that owns it.
    localparam logic [9:0] PHASE_END [4] = '{
        10'(V_PULSE - 1),
        10'(V_PULSE + V_BP - 1),
        10'(V_PULSE + V_BP + V_DISP - 1),
        10'(V_TOTAL - 1)
    };

    state_t     state_reg;
    logic [9:0] line_cnt_reg;
    logic [9:0] line_cnt_next;
    logic [2:0] sub_cnt_reg;
    logic [6:0] vpixel_reg;
    logic       vsync_reg;
    logic       vdisplay_reg;
    logic [3:0] phase_end;
    logic       phase_done;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_phase_end
            assign phase_end[gi] = (line_cnt_reg == PHASE_END[gi]);
        end
    endgenerate

    assign phase_done    = phase_end[state_reg];
    assign line_cnt_next = (line_cnt_reg == LAST_LINE) ? 10'd0 : line_cnt_reg + 10'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= PULSE;
            line_cnt_reg <= 10'd0;
            sub_cnt_reg  <= 3'd0;
            vpixel_reg   <= 7'd0;
            vsync_reg    <= 1'b0;
            vdisplay_reg <= 1'b0;
        end else if (LINE_TICK) begin
            line_cnt_reg <= line_cnt_next;
            case (state_reg)
                PULSE: begin
                    if (phase_done) begin
                        state_reg <= BACK_PORCH;
                        vsync_reg <= 1'b1;
                    end
                end
                BACK_PORCH: begin
                    if (phase_done) begin
                        state_reg    <= DISPLAY;
                        vdisplay_reg <= 1'b1;
                        vpixel_reg   <= 7'd0;
                        sub_cnt_reg  <= 3'd0;
                    end
                end
                DISPLAY: begin
                    if (phase_done) begin
                        // Leaving the visible area overrides the final row step.
                        state_reg    <= FRONT_PORCH;
                        vdisplay_reg <= 1'b0;
                        vpixel_reg   <= 7'd0;
                        sub_cnt_reg  <= 3'd0;
                    end else if (sub_cnt_reg == LAST_SUB) begin
                        sub_cnt_reg <= 3'd0;
                        if (vpixel_reg != LAST_ROW) begin
                            vpixel_reg <= vpixel_reg + 7'd1;
                        end
                    end else begin
                        sub_cnt_reg <= sub_cnt_reg + 3'd1;
                    end
                end
                FRONT_PORCH: begin
                    if (phase_done) begin
                        state_reg <= PULSE;
                        vsync_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= PULSE;
                end
            endcase
        end
    end

`ifdef VSYNC_FRAME_TICK_EN
    logic frame_tick_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= LINE_TICK && (state_reg == FRONT_PORCH) && phase_done;
        end
    end

    assign FRAME_TICK = frame_tick_reg;
`endif

    assign VPIXEL    = vpixel_reg;
    assign VGA_VSYNC = vsync_reg;
    assign VDISPLAY  = vdisplay_reg;

endmodule

// File: tb/tb_vsync.sv
// Self-checking bench for vsync: random tick spacing against a line-number reference model.
`timescale 1ns/1ps
module tb_vsync;

    logic       clk;
    logic       reset;
    logic       LINE_TICK;
    logic [6:0] VPIXEL;
    logic       VGA_VSYNC;
    logic       VDISPLAY;
`ifdef VSYNC_FRAME_TICK_EN
    logic       FRAME_TICK;
`endif

    int checks = 0;
    int errors = 0;
    int model_line = 0;
    logic model_ft = 1'b0;

    vsync dut (
        .clk        (clk),
        .reset      (reset),
        .LINE_TICK  (LINE_TICK),
        .VPIXEL     (VPIXEL),
        .VGA_VSYNC  (VGA_VSYNC),
        .VDISPLAY   (VDISPLAY)
`ifdef VSYNC_FRAME_TICK_EN
        ,
        .FRAME_TICK (FRAME_TICK)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s line=%0d: observed %0d expected %0d", tag, model_line, obs, expv);
        end
    endtask

    // Reference: outputs depend only on which frame line we are on.
    task automatic check_outputs();
        logic vis;
        vis = (model_line >= 31) && (model_line <= 510);
        chk("vsync", 10'(VGA_VSYNC), 10'(model_line >= 2));
        chk("vdisplay", 10'(VDISPLAY), 10'(vis));
        chk("vpixel", 10'(VPIXEL), vis ? 10'((model_line - 31) / 5) : 10'd0);
`ifdef VSYNC_FRAME_TICK_EN
        chk("frame_tick", 10'(FRAME_TICK), 10'(model_ft));
`endif
    endtask

    task automatic cycle(input logic t, input logic r);
        LINE_TICK = t;
        reset     = r;
        @(posedge clk);
        model_ft = !r && t && (model_line == 520);
        if (r) model_line = 0;
        else if (t) model_line = (model_line + 1) % 521;
        #1;
        check_outputs();
    endtask

    // One tick followed by a random idle gap; gap 0 gives back-to-back ticks.
    task automatic tick_random();
        int gap;
        cycle(1'b1, 1'b0);
        gap = $urandom_range(0, 3);
        for (int i = 0; i < gap; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        LINE_TICK = 1'b0;
        reset     = 1'b1;
        @(negedge clk);

        // Reset held with the tick pulsing: outputs stay at line 0.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        // Two full frames plus a little, random spacing.
        for (int i = 0; i < 2 * 521 + 5; i++) tick_random();

        // Held-high LINE_TICK counts every cycle.
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);

        // Advance to line 200 of the next frame.
        while (model_line != 200) tick_random();
        chk("vpixel_at_200", 10'(VPIXEL), 10'd33);

        // Reset coincident with a tick: tick ignored, back to line 0.
        cycle(1'b1, 1'b1);
        chk("rst_vsync_low", 10'(VGA_VSYNC), 10'd0);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) tick_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
